// File: rtl/memory_arbiter.sv
// Two-client round-robin arbiter in front of a single-beat
// Avalon memory driver, with a watchdog that aborts hung transfers.
module memory_arbiter #(
   parameter int ADDR_W  = 26,
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 1023
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              A_READ,
   input  logic              A_WRITE,
   input  logic [ADDR_W-1:0] A_ADDRESS,
   input  logic [DATA_W-1:0] A_WDATA,
   output logic [DATA_W-1:0] A_RDATA,
   output logic              A_DONE,
   input  logic              B_READ,
   input  logic              B_WRITE,
   input  logic [ADDR_W-1:0] B_ADDRESS,
   input  logic [DATA_W-1:0] B_WDATA,
   output logic [DATA_W-1:0] B_RDATA,
   output logic              B_DONE,
   output logic [ADDR_W-1:0] M_ADDRESS,
   output logic [DATA_W-1:0] M_WDATA,
   output logic              M_READ,
   output logic              M_WRITE,
   input  logic [DATA_W-1:0] M_RDATA,
   input  logic              M_PENDING,
   output logic              ERR
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      ACK,
      BUSY,
      DONE
   } state_t;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic        gnt_b;
   logic        last_b;
   logic        op_rd;
   logic [15:0] wd_cnt;

   logic req_a;
   logic req_b;
   logic pick_b;
   logic wd_hit;

   // Request decode and round-robin pick: B wins only if A is idle
   // or A was the last client served.
   always_comb begin
      req_a  = A_READ | A_WRITE;
      req_b  = B_READ | B_WRITE;
      pick_b = req_b & (~req_a | ~last_b);
      wd_hit = (wd_cnt == WD_LAST);
   end

   // Arbitration FSM with registered driver/client outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         gnt_b     <= 1'b0;
         last_b    <= 1'b1;
         op_rd     <= 1'b0;
         wd_cnt    <= '0;
         M_ADDRESS <= '0;
         M_WDATA   <= '0;
         M_READ    <= 1'b0;
         M_WRITE   <= 1'b0;
         A_RDATA   <= '0;
         B_RDATA   <= '0;
         A_DONE    <= 1'b0;
         B_DONE    <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         A_DONE <= 1'b0;
         B_DONE <= 1'b0;
         ERR    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_a | req_b) begin
                  gnt_b     <= pick_b;
                  op_rd     <= pick_b ? B_READ : A_READ;
                  M_ADDRESS <= pick_b ? B_ADDRESS : A_ADDRESS;
                  M_WDATA   <= pick_b ? B_WDATA : A_WDATA;
                  M_READ    <= pick_b ? B_READ : A_READ;
                  M_WRITE   <= pick_b ? ~B_READ : ~A_READ;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               M_READ  <= 1'b0;
               M_WRITE <= 1'b0;
               wd_cnt  <= '0;
               state   <= ACK;
            end
            ACK: begin
               wd_cnt <= wd_cnt + 16'd1;
               if (wd_hit) begin
                  ERR    <= 1'b1;
                  A_DONE <= ~gnt_b;
                  B_DONE <= gnt_b;
                  state  <= DONE;
               end else if (M_PENDING) begin
                  state <= BUSY;
               end
            end
            BUSY: begin
               wd_cnt <= wd_cnt + 16'd1;
               if (!M_PENDING) begin
                  if (op_rd && !gnt_b) A_RDATA <= M_RDATA;
                  if (op_rd && gnt_b)  B_RDATA <= M_RDATA;
                  A_DONE <= ~gnt_b;
                  B_DONE <= gnt_b;
                  state  <= DONE;
               end else if (wd_hit) begin
                  ERR    <= 1'b1;
                  A_DONE <= ~gnt_b;
                  B_DONE <= gnt_b;
                  state  <= DONE;
               end
            end
            DONE: begin
               last_b <= gnt_b;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a simple driver model
// whose PENDING length and hang behaviour are set per step.
module tb_memory_arbiter;

   localparam int AW = 26;
   localparam int DW = 128;
   localparam logic [127:0] DB =
      128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          A_READ = 1'b0;
   logic          A_WRITE = 1'b0;
   logic [AW-1:0] A_ADDRESS = '0;
   logic [DW-1:0] A_WDATA = '0;
   logic [DW-1:0] A_RDATA;
   logic          A_DONE;
   logic          B_READ = 1'b0;
   logic          B_WRITE = 1'b0;
   logic [AW-1:0] B_ADDRESS = '0;
   logic [DW-1:0] B_WDATA = '0;
   logic [DW-1:0] B_RDATA;
   logic          B_DONE;
   logic [AW-1:0] M_ADDRESS;
   logic [DW-1:0] M_WDATA;
   logic          M_READ;
   logic          M_WRITE;
   logic [DW-1:0] M_RDATA = '0;
   logic          M_PENDING = 1'b0;
   logic          ERR;

   memory_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(16)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .A_READ   (A_READ),
      .A_WRITE  (A_WRITE),
      .A_ADDRESS(A_ADDRESS),
      .A_WDATA  (A_WDATA),
      .A_RDATA  (A_RDATA),
      .A_DONE   (A_DONE),
      .B_READ   (B_READ),
      .B_WRITE  (B_WRITE),
      .B_ADDRESS(B_ADDRESS),
      .B_WDATA  (B_WDATA),
      .B_RDATA  (B_RDATA),
      .B_DONE   (B_DONE),
      .M_ADDRESS(M_ADDRESS),
      .M_WDATA  (M_WDATA),
      .M_READ   (M_READ),
      .M_WRITE  (M_WRITE),
      .M_RDATA  (M_RDATA),
      .M_PENDING(M_PENDING),
      .ERR      (ERR)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // driver model: PENDING high for pend_len cycles after a command
   int pend_len  = 1;
   int pend_left = 0;
   bit hang      = 1'b0;

   always @(posedge CLK) begin
      if (RESET) begin
         pend_left <= 0;
         M_PENDING <= 1'b0;
      end else if ((M_READ || M_WRITE) && !hang) begin
         M_PENDING <= 1'b1;
         pend_left <= pend_len - 1;
      end else if (pend_left > 0) begin
         pend_left <= pend_left - 1;
      end else begin
         M_PENDING <= 1'b0;
      end
   end

   // monitor: pulse counters and issue logs
   int n_mrd = 0;
   int n_mwr = 0;
   int n_ad  = 0;
   int n_bd  = 0;
   int n_err = 0;
   logic [AW-1:0] rd_log[$];
   logic [AW-1:0] wr_alog[$];
   logic [DW-1:0] wr_dlog[$];

   always @(posedge CLK) begin
      if (M_READ) begin
         n_mrd++;
         rd_log.push_back(M_ADDRESS);
      end
      if (M_WRITE) begin
         n_mwr++;
         wr_alog.push_back(M_ADDRESS);
         wr_dlog.push_back(M_WDATA);
      end
      if (A_DONE) n_ad++;
      if (B_DONE) n_bd++;
      if (ERR) n_err++;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input bit for_b, input int limit,
                            input string tag, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!(for_b ? B_DONE : A_DONE) && cyc < limit);
      chk(tag, for_b ? B_DONE : A_DONE, 1'b1);
   endtask

   int s_mrd, s_mwr, s_ad, s_bd, s_err;
   int cyc, base, got, first_b;

   task automatic snap;
      s_mrd = n_mrd;
      s_mwr = n_mwr;
      s_ad  = n_ad;
      s_bd  = n_bd;
      s_err = n_err;
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_mread", M_READ, 1'b0);
      chk("rst_mwrite", M_WRITE, 1'b0);
      chk("rst_adone", A_DONE, 1'b0);
      chk("rst_bdone", B_DONE, 1'b0);
      chk("rst_err", ERR, 1'b0);
      chk("rst_maddr", M_ADDRESS, '0);
      chk("rst_ardata", A_RDATA, '0);
      RESET = 1'b0;
      tick();

      // 1: single read from A, 3 PENDING cycles
      pend_len = 3;
      M_RDATA = DB;
      snap();
      A_ADDRESS = 26'h10;
      A_READ = 1'b1;
      wait_done(1'b0, 40, "t1_done", cyc);
      chk("t1_latency", cyc, 6);
      chk("t1_rdata", A_RDATA, DB);
      chk("t1_bdone", B_DONE, 1'b0);
      A_READ = 1'b0;
      tick();
      chk("t1_pulse", A_DONE, 1'b0);
      tick();
      tick();
      chk("t1_nread", n_mrd - s_mrd, 1);
      chk("t1_nadone", n_ad - s_ad, 1);
      chk("t1_nbdone", n_bd - s_bd, 0);
      chk("t1_raddr", rd_log[rd_log.size()-1], 26'h10);
      chk("t1_brdata", B_RDATA, '0);

      // 2: simultaneous writes after reset, A first
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      chk("t2_rst_rdata", A_RDATA, '0);
      pend_len = 1;
      snap();
      base = wr_alog.size();
      A_ADDRESS = 26'h100;
      A_WDATA = 128'hA1;
      B_ADDRESS = 26'h200;
      B_WDATA = 128'hB2;
      A_WRITE = 1'b1;
      B_WRITE = 1'b1;
      got = 0;
      first_b = -1;
      cyc = 0;
      while (got < 2 && cyc < 60) begin
         tick();
         cyc++;
         if (A_DONE) begin
            if (first_b < 0) first_b = 0;
            got++;
            A_WRITE = 1'b0;
         end
         if (B_DONE) begin
            if (first_b < 0) first_b = 1;
            got++;
            B_WRITE = 1'b0;
         end
      end
      chk("t2_both_done", got, 2);
      chk("t2_first_a", first_b, 0);
      tick();
      tick();
      chk("t2_nwrite", n_mwr - s_mwr, 2);
      chk("t2_nread", n_mrd - s_mrd, 0);
      chk("t2_nadone", n_ad - s_ad, 1);
      chk("t2_nbdone", n_bd - s_bd, 1);
      chk("t2_addr0", wr_alog[base], 26'h100);
      chk("t2_data0", wr_dlog[base], 128'hA1);
      chk("t2_addr1", wr_alog[base+1], 26'h200);
      chk("t2_data1", wr_dlog[base+1], 128'hB2);

      // 3: both hold reads for 8 transactions
      snap();
      base = rd_log.size();
      A_ADDRESS = 26'h1A;
      B_ADDRESS = 26'h1B;
      A_READ = 1'b1;
      B_READ = 1'b1;
      got = 0;
      cyc = 0;
      while (got < 8 && cyc < 200) begin
         tick();
         cyc++;
         if (A_DONE || B_DONE) got++;
      end
      A_READ = 1'b0;
      B_READ = 1'b0;
      tick();
      tick();
      chk("t3_count", got, 8);
      chk("t3_nadone", n_ad - s_ad, 4);
      chk("t3_nbdone", n_bd - s_bd, 4);
      chk("t3_nread", rd_log.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < rd_log.size())
            chk($sformatf("t3_order%0d", i), rd_log[base+i],
                (i % 2) ? 26'h1B : 26'h1A);
         else
            chk($sformatf("t3_missing%0d", i), 1'b0, 1'b1);
      end
      chk("t3_ardata", A_RDATA, DB);

      // 4: driver hangs, watchdog aborts after 16 cycles
      hang = 1'b1;
      M_RDATA = 128'hBAD;
      snap();
      A_ADDRESS = 26'h55;
      A_READ = 1'b1;
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!M_READ && cyc < 10);
      chk("t4_issue", M_READ, 1'b1);
      tick();
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!ERR && cyc < 40);
      chk("t4_err", ERR, 1'b1);
      chk("t4_cycles", cyc, 16);
      chk("t4_done_with_err", A_DONE, 1'b1);
      chk("t4_rdata_kept", A_RDATA, DB);
      A_READ = 1'b0;
      tick();
      chk("t4_err_pulse", ERR, 1'b0);
      chk("t4_done_pulse", A_DONE, 1'b0);
      hang = 1'b0;
      pend_len = 1;
      M_RDATA = 128'h1234;
      B_ADDRESS = 26'h66;
      B_READ = 1'b1;
      wait_done(1'b1, 20, "t4_after_done", cyc);
      chk("t4_after_latency", cyc, 4);
      chk("t4_after_rdata", B_RDATA, 128'h1234);
      chk("t4_after_err", ERR, 1'b0);
      B_READ = 1'b0;
      tick();

      // 5: reset during BUSY, request re-issued afterwards
      pend_len = 5;
      M_RDATA = 128'h5555;
      snap();
      A_ADDRESS = 26'h77;
      A_READ = 1'b1;
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!M_READ && cyc < 10);
      chk("t5_issue", M_READ, 1'b1);
      tick();
      tick();
      RESET = 1'b1;
      tick();
      chk("t5_rst_mread", M_READ, 1'b0);
      chk("t5_rst_mwrite", M_WRITE, 1'b0);
      chk("t5_rst_adone", A_DONE, 1'b0);
      chk("t5_rst_err", ERR, 1'b0);
      chk("t5_rst_rdata", A_RDATA, '0);
      chk("t5_rst_maddr", M_ADDRESS, '0);
      RESET = 1'b0;
      s_mrd = n_mrd;
      wait_done(1'b0, 40, "t5_done", cyc);
      chk("t5_rdata", A_RDATA, 128'h5555);
      A_READ = 1'b0;
      tick();
      tick();
      chk("t5_nread", n_mrd - s_mrd, 1);
      chk("t5_nadone", n_ad - s_ad, 1);

      // 6: B asserts read and write together at top address
      pend_len = 1;
      M_RDATA = 128'h6666;
      snap();
      B_ADDRESS = 26'h3FFFFFF;
      B_WDATA = 128'hFF;
      B_READ = 1'b1;
      B_WRITE = 1'b1;
      wait_done(1'b1, 20, "t6_done", cyc);
      chk("t6_maddr", M_ADDRESS, 26'h3FFFFFF);
      chk("t6_rdata", B_RDATA, 128'h6666);
      B_READ = 1'b0;
      B_WRITE = 1'b0;
      tick();
      tick();
      chk("t6_nread", n_mrd - s_mrd, 1);
      chk("t6_nwrite", n_mwr - s_mwr, 0);
      chk("t6_nbdone", n_bd - s_bd, 1);
      chk("t6_nadone", n_ad - s_ad, 0);
      chk("t6_raddr", rd_log[rd_log.size()-1], 26'h3FFFFFF);
      chk("t6_nerr", n_err - s_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
